// File: rtl/edge_skew_feeder_pkg.sv
// Shared systolic-array types for the edge skew feeder.
// Holds the feeder FSM state type and stall counter helpers.
package edge_skew_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } feeder_state_e;

  localparam int STALL_CNT_W = 32;

  typedef logic [STALL_CNT_W-1:0] stall_cnt_t;

  // Saturating increment for the stall counter.
  function automatic stall_cnt_t sat_inc(input stall_cnt_t v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/edge_skew_feeder_if.sv
// Upstream row-vector handshake into the edge skew feeder.
// master drives vectors, slave (the feeder) returns ready.
interface edge_skew_feeder_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int PE_PER_SIDE = 6
) ();

  logic                              in_valid;
  logic                              in_ready;
  logic [DATA_WIDTH*PE_PER_SIDE-1:0] in_data;
  logic                              in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/edge_skew_feeder_skew_delay_line.sv
// One lane of the skew network: DEPTH+1 register stages.
// Lane i therefore lands i+1 enabled cycles after its pop.
module skew_delay_line #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid
);

  localparam int N = DEPTH + 1;

  logic [DATA_WIDTH-1:0] data_q [N];
  logic [N-1:0]          valid_q;

  // Shift chain; clear beats enable so a flush wins over a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) data_q[k] <= '0;
      valid_q <= '0;
    end else if (clr) begin
      for (int k = 0; k < N; k++) data_q[k] <= '0;
      valid_q <= '0;
    end else if (en) begin
      data_q[0]  <= in_data;
      valid_q[0] <= in_valid;
      for (int k = 1; k < N; k++) begin
        data_q[k]  <= data_q[k-1];
        valid_q[k] <= valid_q[k-1];
      end
    end
  end

  assign out_data  = data_q[DEPTH];
  assign out_valid = valid_q[DEPTH];

endmodule

// File: rtl/edge_skew_feeder.sv
// Row-vector FIFO plus per-lane skew feeding a systolic edge.
// Optional stall counter: define EDGE_SKEW_FEEDER_PERF_CNT_EN.
module edge_skew_feeder
  import edge_skew_feeder_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int PE_PER_SIDE = 6,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  edge_skew_feeder_if.slave                   up,
  input  logic                                array_stall,
  input  logic                                flush,
  output logic [DATA_WIDTH*PE_PER_SIDE-1:0]   out_data,
  output logic [PE_PER_SIDE-1:0]              out_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count,
`ifdef EDGE_SKEW_FEEDER_PERF_CNT_EN
  output logic [STALL_CNT_W-1:0]              stall_cycles,
`endif
  output logic                                busy
);

  localparam int VW  = DATA_WIDTH * PE_PER_SIDE;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int DCW = $clog2(PE_PER_SIDE + 1);

  logic [VW-1:0]         mem_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_last;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic [DCW-1:0]        drain_q;
  feeder_state_e         state_q;
  feeder_state_e         state_d;
  logic                  push;
  logic                  pop;
  logic                  head_last;
  logic [VW-1:0]         lane_in;

  // Ready only looks at the stored count, never at pop.
  assign up.in_ready = (count_q < CW'(FIFO_DEPTH)) && !flush;

  assign push = up.in_valid && up.in_ready;
  assign pop  = (state_q == STREAM) && (count_q != '0)
             && !array_stall && !flush;

  assign head_last = mem_last[rd_ptr];
  assign lane_in   = pop ? mem_data[rd_ptr] : '0;

  // Vector and tile-end storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < FIFO_DEPTH; k++) mem_data[k] <= '0;
      mem_last <= '0;
    end else if (push) begin
      mem_data[wr_ptr] <= up.in_data;
      mem_last[wr_ptr] <= up.in_last;
    end
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: a tile end forces a full drain before new pops.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:
          if (count_q != '0) state_d = STREAM;
        STREAM:
          if (pop && head_last) state_d = DRAIN;
        DRAIN:
          if (!array_stall &&
              drain_q == DCW'(PE_PER_SIDE - 1))
            state_d = IDLE;
        default:
          state_d = IDLE;
      endcase
    end
  end

  // Counts non-stalled drain cycles; idle outside DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drain_q <= '0;
    else if (flush || state_q != DRAIN)
      drain_q <= '0;
    else if (!array_stall)
      drain_q <= drain_q + 1'b1;
  end

  for (genvar i = 0; i < PE_PER_SIDE; i++) begin : g_lane
    skew_delay_line #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (i)
    ) u_dl (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (!array_stall),
      .clr       (flush),
      .in_data   (lane_in[i*DATA_WIDTH +: DATA_WIDTH]),
      .in_valid  (pop),
      .out_data  (out_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .out_valid (out_valid[i])
    );
  end

  assign fifo_count = count_q;
  assign busy       = (count_q != '0) || (state_q != IDLE);

`ifdef EDGE_SKEW_FEEDER_PERF_CNT_EN
  stall_cnt_t stall_q;

  // Cycles the array held us off while work was pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    stall_q <= '0;
    else if (flush)                stall_q <= '0;
    else if (array_stall && busy)  stall_q <= sat_inc(stall_q);
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_edge_skew_feeder.sv
// Self-checking bench for edge_skew_feeder.
// Reference model: FIFO queue, tile mode, pop history by tick.
module tb_edge_skew_feeder;

  typedef logic [47:0] vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  vec_t        out_data;
  logic [5:0]  out_valid;
  logic [2:0]  fifo_count;
  logic        busy;
  logic [31:0] stall_cycles;
  logic [58:0] got;

  edge_skew_feeder_if #(.DATA_WIDTH(8), .PE_PER_SIDE(6)) bus ();

  edge_skew_feeder #(
    .DATA_WIDTH  (8),
    .PE_PER_SIDE (6),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .up           (bus),
    .array_stall  (stall),
    .flush        (flush),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .fifo_count   (fifo_count),
`ifdef EDGE_SKEW_FEEDER_PERF_CNT_EN
    .stall_cycles (stall_cycles),
`endif
    .busy         (busy)
  );

`ifndef EDGE_SKEW_FEEDER_PERF_CNT_EN
  assign stall_cycles = '0;
`endif

  always #5 clk = ~clk;

  assign got = {out_data, out_valid, fifo_count,
                busy, bus.in_ready};

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model state: 0 idle, 1 streaming, 2 draining.
  vec_t        mq[$];
  bit          ml[$];
  int          mstate = 0;
  int          drain_left = 0;
  vec_t        hd[16];
  bit          hv[16];
  int          ntick = 0;
  logic [31:0] mstall = '0;

  function automatic void model_clear();
    mq.delete();
    ml.delete();
    mstate = 0;
    drain_left = 0;
    for (int i = 0; i < 16; i++) begin
      hv[i] = 1'b0;
      hd[i] = '0;
    end
  endfunction

  // Apply one clock edge using the inputs now on the pins.
  function automatic void model_edge();
    bit rdy;
    bit pop;
    bit bsy;
    rdy = (mq.size() < 4) && !flush;
    bsy = (mq.size() > 0) || (mstate != 0);
    if (flush) begin
      model_clear();
      mstall = '0;
      return;
    end
    if (stall && bsy && mstall != 32'hffff_ffff)
      mstall = mstall + 1;
    pop = (mstate == 1) && (mq.size() > 0) && !stall;
    case (mstate)
      0: if (mq.size() > 0) mstate = 1;
      1: if (pop && ml[0]) begin
           mstate = 2;
           drain_left = 6;
         end
      default: if (!stall) begin
           drain_left--;
           if (drain_left == 0) mstate = 0;
         end
    endcase
    if (!stall) begin
      hv[ntick % 16] = pop;
      hd[ntick % 16] = pop ? mq[0] : '0;
      ntick++;
    end
    if (pop) begin
      void'(mq.pop_front());
      void'(ml.pop_front());
    end
    if (bus.in_valid && rdy) begin
      mq.push_back(bus.in_data);
      ml.push_back(bus.in_last);
    end
  endfunction

  // Lane i shows whatever was popped i+1 ticks ago.
  function automatic logic [58:0] exp_vec();
    vec_t       od;
    logic [5:0] ov;
    int         idx;
    od = '0;
    ov = '0;
    for (int i = 0; i < 6; i++) begin
      idx = ntick - 1 - i;
      if (idx >= 0 && hv[idx % 16]) begin
        ov[i] = 1'b1;
        od[i*8 +: 8] = hd[idx % 16][i*8 +: 8];
      end
    end
    return {od, ov, 3'(mq.size()),
            (mq.size() > 0) || (mstate != 0),
            (mq.size() < 4) && !flush};
  endfunction

  task automatic set_in(input bit v, input vec_t d,
                        input bit l, input bit s,
                        input bit f);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = l;
    stall        = s;
    flush        = f;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic vec_t rvec();
    return vec_t'({$urandom(), $urandom()});
  endfunction

  task automatic do_reset(input string nm);
    set_in(0, '0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    mstall = '0;
    checks++;
    if (got !== exp_vec()) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp_vec());
    end
    checks++;
    if (stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL %s_stall got=%0d exp=0",
               nm, stall_cycles);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int bad;
    vec_t v;
    do_reset("reset");
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (got !== exp_vec()) begin
        errors++;
        $display("FAIL reset_idle got=%h exp=%h",
                 got, exp_vec());
      end
    end
    v = rvec();
    set_in(1, v, 1, 0, 0);
    step();
    set_in(0, '0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (got !== exp_vec()) begin
        errors++;
        $display("FAIL midtile got=%h exp=%h",
                 got, exp_vec());
      end
    end
    do_reset("midtile_reset");
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (out_valid !== 6'd0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL post_reset_out got=%0d bad exp=0", bad);
    end
  endtask

  task automatic test_single();
    vec_t v;
    int   first[6];
    int   val[6];
    bit   b7;
    bit   b8;
    for (int i = 0; i < 6; i++) begin
      v[i*8 +: 8] = 8'(i + 1);
      first[i] = -1;
      val[i] = 0;
    end
    b7 = 0;
    b8 = 1;
    set_in(1, v, 1, 0, 0);
    for (int k = 0; k <= 10; k++) begin
      step();
      if (k == 0) set_in(0, '0, 0, 0, 0);
      checks++;
      if (got !== exp_vec()) begin
        errors++;
        $display("FAIL single k=%0d got=%h exp=%h",
                 k, got, exp_vec());
      end
      for (int i = 0; i < 6; i++)
        if (out_valid[i] && first[i] < 0) begin
          first[i] = k;
          val[i] = int'(out_data[i*8 +: 8]);
        end
      if (k == 7) b7 = busy;
      if (k == 8) b8 = busy;
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (first[i] != 2 + i || val[i] != i + 1) begin
        errors++;
        $display("FAIL single_lane%0d got=k%0d/%0d exp=k%0d/%0d",
                 i, first[i], val[i], 2 + i, i + 1);
      end
    end
    checks++;
    if (b7 !== 1'b1 || b8 !== 1'b0) begin
      errors++;
      $display("FAIL single_idle got=%b%b exp=10", b7, b8);
    end
  endtask

  task automatic test_fifo_full();
    set_in(0, '0, 0, 0, 1);
    step();
    for (int n = 0; n < 4; n++) begin
      set_in(1, rvec(), 0, 1, 0);
      step();
      checks++;
      if (got !== exp_vec()) begin
        errors++;
        $display("FAIL full_push%0d got=%h exp=%h",
                 n, got, exp_vec());
      end
    end
    set_in(1, rvec(), 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (fifo_count !== 3'd4 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL full_hold got=%0d/%b exp=4/0",
                 fifo_count, bus.in_ready);
      end
    end
    stall = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (fifo_count !== 3'd3 || got !== exp_vec()) begin
        errors++;
        $display("FAIL full_pop%0d got=%h exp=%h",
                 k, got, exp_vec());
      end
    end
    set_in(0, '0, 0, 0, 0);
    for (int k = 0; k < 12; k++) begin
      step();
      checks++;
      if (got !== exp_vec()) begin
        errors++;
        $display("FAIL full_drain got=%h exp=%h",
                 got, exp_vec());
      end
    end
  endtask

  task automatic test_stall();
    vec_t snap;
    logic [5:0] vsnap;
    int first5;
    first5 = -1;
    set_in(0, '0, 0, 0, 1);
    step();
    set_in(1, rvec(), 1, 0, 0);
    for (int k = 0; k <= 14; k++) begin
      step();
      if (k == 0) set_in(0, '0, 0, 0, 0);
      if (k == 4) begin
        snap = out_data;
        vsnap = out_valid;
        stall = 1'b1;
      end
      if (k == 7) stall = 1'b0;
      checks++;
      if (got !== exp_vec()) begin
        errors++;
        $display("FAIL stall k=%0d got=%h exp=%h",
                 k, got, exp_vec());
      end
      if (k >= 5 && k <= 7) begin
        checks++;
        if (out_data !== snap || out_valid !== vsnap) begin
          errors++;
          $display("FAIL stall_freeze got=%h exp=%h",
                   out_data, snap);
        end
      end
      if (out_valid[5] && first5 < 0) first5 = k;
    end
    checks++;
    if (first5 != 10) begin
      errors++;
      $display("FAIL stall_shift got=%0d exp=10", first5);
    end
  endtask

  task automatic test_flush();
    int bad;
    set_in(0, '0, 0, 0, 1);
    step();
    set_in(1, rvec(), 0, 0, 0);
    step();
    set_in(1, rvec(), 1, 0, 0);
    step();
    set_in(0, '0, 0, 0, 0);
    step();
    step();
    set_in(1, rvec(), 1, 0, 1);
    step();
    checks++;
    if (fifo_count !== 3'd0 || out_valid !== 6'd0 ||
        busy !== 1'b0) begin
      errors++;
      $display("FAIL flush got=%0d/%b/%b exp=0/0/0",
               fifo_count, out_valid, busy);
    end
    set_in(0, '0, 0, 0, 0);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (out_valid !== 6'd0 || got !== exp_vec()) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL flush_absent got=%0d bad exp=0", bad);
    end
  endtask

  task automatic test_back_to_back();
    int l0[$];
    int bad;
    set_in(0, '0, 0, 0, 1);
    step();
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      case (k)
        0: set_in(1, rvec(), 0, 0, 0);
        1: set_in(1, rvec(), 1, 0, 0);
        2: set_in(1, rvec(), 0, 0, 0);
        3: set_in(1, rvec(), 1, 0, 0);
        default: set_in(0, '0, 0, 0, 0);
      endcase
      step();
      checks++;
      if (got !== exp_vec()) begin
        errors++;
        $display("FAIL b2b k=%0d got=%h exp=%h",
                 k, got, exp_vec());
      end
      if (out_valid[0]) l0.push_back(k);
      if (k >= 4 && k <= 9 && fifo_count !== 3'd2) bad++;
    end
    checks++;
    if (l0.size() != 4 || l0[0] != 2 || l0[1] != 3 ||
        l0[2] != 11 || l0[3] != 12) begin
      errors++;
      $display("FAIL b2b_lane0 got=%p exp=2,3,11,12", l0);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b2b_nopop got=%0d bad exp=0", bad);
    end
  endtask

  task automatic test_perf();
`ifdef EDGE_SKEW_FEEDER_PERF_CNT_EN
    set_in(0, '0, 0, 0, 1);
    step();
    set_in(1, rvec(), 1, 1, 0);
    step();
    set_in(0, '0, 0, 1, 0);
    for (int k = 0; k < 10; k++) step();
    checks++;
    if (stall_cycles !== 32'd10 || stall_cycles !== mstall) begin
      errors++;
      $display("FAIL perf_count got=%0d exp=10", stall_cycles);
    end
    do_reset("perf_reset");
`endif
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      set_in($urandom_range(0, 1) == 1, rvec(),
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 4) == 0,
             $urandom_range(0, 49) == 0);
      step();
      checks++;
      if (got !== exp_vec()) begin
        errors++;
        $display("FAIL random k=%0d got=%h exp=%h",
                 k, got, exp_vec());
      end
`ifdef EDGE_SKEW_FEEDER_PERF_CNT_EN
      checks++;
      if (stall_cycles !== mstall) begin
        errors++;
        $display("FAIL random_perf got=%0d exp=%0d",
                 stall_cycles, mstall);
      end
`endif
    end
  endtask

  initial begin
    set_in(0, '0, 0, 0, 0);
    repeat (2) @(posedge clk);
    test_reset();
    test_single();
    test_fifo_full();
    test_stall();
    test_flush();
    test_back_to_back();
    test_perf();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/edge_skew_feeder.md
EDGE_SKEW_FEEDER -- requirements
Module: edge_skew_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, element width in bits.
REQ-002 SHALL have parameter PE_PER_SIDE, default 6, lanes per array edge.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, row-vector FIFO entries; power of two, at least 2.
REQ-004 SHALL have port clk  input  1  single clock; all state rises on posedge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  upstream vector valid.
REQ-007 SHALL have port in_ready  output  1  FIFO can accept a vector.
REQ-008 SHALL have port in_data  input  DATA_WIDTH*PE_PER_SIDE  row vector; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port in_last  input  1  vector is last of tile.
REQ-010 SHALL have port array_stall  input  1  freeze pops and skew shifting.
REQ-011 SHALL have port flush  input  1  synchronous clear of all contents.
REQ-012 SHALL have port out_data  output  DATA_WIDTH*PE_PER_SIDE  skewed vector to the systolic-array edge buffer input.
REQ-013 SHALL have port out_valid  output  PE_PER_SIDE  per-lane valid of out_data.
REQ-014 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH+1)  stored vector count.
REQ-015 SHALL have port busy  output  1  FIFO non-empty or state not IDLE.

Function
REQ-016 SHALL push on in_valid && in_ready; in_ready = (fifo_count < FIFO_DEPTH) && !flush, with no combinational path from pop.
REQ-017 SHALL pop one vector per cycle when state is STREAM, FIFO non-empty and array_stall low.
REQ-018 SHALL present lane i of a vector popped at cycle t on out_data lane i, with out_valid[i]=1, at cycle t+1+i, counting only non-stalled cycles.
REQ-019 SHALL inject zero data with valid 0 into lane delay lines on non-stalled cycles without a pop.
REQ-020 SHALL hold FIFO, delay lines, outputs and drain counter unchanged while array_stall is high; pushes still accepted.
REQ-021 SHALL implement states IDLE, STREAM, DRAIN: IDLE->STREAM when FIFO non-empty; STREAM->DRAIN on pop of a vector with in_last set; DRAIN->IDLE after PE_PER_SIDE non-stalled cycles; DRAIN->STREAM never directly.
REQ-022 SHALL inhibit pops in DRAIN so tiles never overlap on the edge.
REQ-023 SHALL store in_last per FIFO entry alongside data.
REQ-024 SHALL on flush clear FIFO pointers, count, delay lines, out_valid and drain counter, enter IDLE next cycle; flush overrides simultaneous push, pop and stall.
REQ-025 SHALL support simultaneous push and pop with fifo_count unchanged; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-026 SHALL on rst_n low asynchronously clear: state IDLE, fifo_count 0, out_data 0, out_valid 0, busy 0, pointers 0; in_ready 1 after release.
REQ-027 SHALL discard in-flight data on reset mid-tile; no partial output after release.

Configuration
REQ-028 SHALL, with macro EDGE_SKEW_FEEDER_PERF_CNT_EN defined, add output stall_cycles (32 bits) counting cycles with array_stall high and busy high, saturating at all-ones, cleared by reset and flush.
REQ-029 SHALL, without EDGE_SKEW_FEEDER_PERF_CNT_EN, omit the port and counter entirely.

Structure
REQ-030 SHALL place feeder_state_e (IDLE, STREAM, DRAIN) in a shared package with the other systolic-array typedefs.
REQ-031 SHALL instantiate one sub-module, skew_delay_line, per lane, parameterised by depth (lane index).

Verification
REQ-032 SHALL check single vector lanes 0..5 = 1..6, in_last=1, PE_PER_SIDE=6 -> lane i shows i+1 at cycle pop+1+i; IDLE after 6 drain cycles.
REQ-033 SHALL check 5 pushes with no pops at FIFO_DEPTH=4 -> 4 accepted, in_ready low, fifo_count 4, fifth held until pop.
REQ-034 SHALL check array_stall high 3 cycles mid-tile -> out_data/out_valid frozen; skew timing resumes shifted by 3.
REQ-035 SHALL check flush with push in same cycle -> fifo_count 0, out_valid 0, state IDLE; pushed vector absent.
REQ-036 SHALL check two back-to-back tiles, first ending in_last -> no pop during 6 DRAIN cycles; second tile lane 0 starts after.
REQ-037 SHALL check with macro, 10 stall cycles while busy -> stall_cycles = 10; reset -> 0.
